// File: rtl/regfile_banked.sv
// regfile_banked
//   Multi-bank register file with a single-level context switch. All ports
//   address the bank held in cur_bank; ctx_save jumps to ctx_bank and
//   remembers the previous bank, ctx_restore jumps back.
//
// Parameters
//   WIDTH   data width of every register
//   AW      address width (2^AW registers per bank)
//   NBANK   number of banks (power of two, >= 2)
//   ZERO_R0 1 = register 0 of every bank reads 0 and ignores writes
//   BYPASS  1 = a read of the address being written returns wd3 this cycle
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   we3, wa3, wd3     write port (applied at the rising edge)
//   ra1/rd1, ra2/rd2  combinational read ports
//   ctx_save, ctx_bank, ctx_restore   context requests
//   cur_bank          bank addressed by all ports
//   ctx_active        a saved context is held
//   ctx_err           sticky protocol-error flag
module regfile_banked #(
    parameter int WIDTH   = 8,
    parameter int AW      = 4,
    parameter int NBANK   = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we3,
    input  logic [AW-1:0]              ra1,
    input  logic [AW-1:0]              ra2,
    input  logic [AW-1:0]              wa3,
    input  logic [WIDTH-1:0]           wd3,
    output logic [WIDTH-1:0]           rd1,
    output logic [WIDTH-1:0]           rd2,
    input  logic                       ctx_save,
    input  logic [$clog2(NBANK)-1:0]   ctx_bank,
    input  logic                       ctx_restore,
    output logic [$clog2(NBANK)-1:0]   cur_bank,
    output logic                       ctx_active,
    output logic                       ctx_err
);
    localparam int BW   = $clog2(NBANK);
    localparam int IW   = BW + AW;
    localparam int NREG = 1 << IW;

    typedef enum logic {IDLE, SAVED} state_t;

    state_t          state_reg;
    logic [BW-1:0]   cur_bank_reg;
    logic [BW-1:0]   saved_bank_reg;
    logic            ctx_err_reg;

    // Flattened storage: index = {bank, address}.
    logic [WIDTH-1:0] rows [NREG];
    logic [IW-1:0]    widx;
    logic             wr_ok;

    assign widx  = {cur_bank_reg, wa3};
    assign wr_ok = we3 && !((ZERO_R0 != 0) && (wa3 == '0));

    // One flop row per register so that the whole file clears on reset
    // (a RAM macro cannot be reset in one cycle).
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic [WIDTH-1:0] r_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_reg <= '0;
                end else if (wr_ok && (widx == IW'(gi))) begin
                    r_reg <= wd3;
                end
            end
            assign rows[gi] = r_reg;
        end
    endgenerate

    // Zero register wins over bypass; bypass only ever matches the current
    // bank because reads and writes share cur_bank.
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = rows[{cur_bank_reg, a}];
        if ((BYPASS != 0) && we3 && (wa3 == a)) begin
            v = wd3;
        end
        if ((ZERO_R0 != 0) && (a == '0)) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

    // Context FSM. Any illegal request combination only raises the sticky
    // error and leaves state and both bank registers untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cur_bank_reg   <= '0;
            saved_bank_reg <= '0;
            ctx_err_reg    <= 1'b0;
        end else if (ctx_save && ctx_restore) begin
            ctx_err_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ctx_save) begin
                        saved_bank_reg <= cur_bank_reg;
                        cur_bank_reg   <= ctx_bank;
                        state_reg      <= SAVED;
                    end else if (ctx_restore) begin
                        ctx_err_reg <= 1'b1;
                    end
                end
                SAVED: begin
                    if (ctx_restore) begin
                        cur_bank_reg <= saved_bank_reg;
                        state_reg    <= IDLE;
                    end else if (ctx_save) begin
                        ctx_err_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cur_bank   = cur_bank_reg;
    assign ctx_active = (state_reg == SAVED);
    assign ctx_err    = ctx_err_reg;
endmodule

// File: tb/tb_regfile_banked.sv
module tb_regfile_banked;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       we3 = 1'b0;
    logic [3:0] ra1 = '0, ra2 = '0, wa3 = '0;
    logic [7:0] wd3 = '0;
    logic       ctx_save = 1'b0, ctx_restore = 1'b0;
    logic [0:0] ctx_bank = '0;
    logic [7:0] rd1, rd2, rd1_nb, rd2_nb;
    logic [0:0] cur_bank, cur_bank_nb;
    logic       ctx_active, ctx_active_nb, ctx_err, ctx_err_nb;

    int tests = 0;
    int fails = 0;

    // Reference state
    logic [7:0] m_mem [2][16];
    logic [0:0] m_bank, m_saved;
    bit         m_active, m_err;

    always #5 clk = ~clk;

    regfile_banked #(.WIDTH(8), .AW(4), .NBANK(2), .ZERO_R0(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .we3(we3), .ra1(ra1), .ra2(ra2), .wa3(wa3),
        .wd3(wd3), .rd1(rd1), .rd2(rd2), .ctx_save(ctx_save), .ctx_bank(ctx_bank),
        .ctx_restore(ctx_restore), .cur_bank(cur_bank), .ctx_active(ctx_active),
        .ctx_err(ctx_err));

    regfile_banked #(.WIDTH(8), .AW(4), .NBANK(2), .ZERO_R0(1), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .we3(we3), .ra1(ra1), .ra2(ra2), .wa3(wa3),
        .wd3(wd3), .rd1(rd1_nb), .rd2(rd2_nb), .ctx_save(ctx_save), .ctx_bank(ctx_bank),
        .ctx_restore(ctx_restore), .cur_bank(cur_bank_nb), .ctx_active(ctx_active_nb),
        .ctx_err(ctx_err_nb));

    // Expected read value from the current inputs and reference state.
    function automatic logic [7:0] exp_rd(input logic [3:0] a, input bit byp);
        if (a == 4'd0) return 8'h00;
        if (byp && we3 && wa3 == a) return wd3;
        return m_mem[m_bank][a];
    endfunction

    // Apply the current inputs to the reference state, then advance one clock.
    task automatic tick();
        if (reset) begin
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 16; a++) m_mem[b][a] = 8'h00;
            m_bank = 0; m_saved = 0; m_active = 0; m_err = 0;
        end else begin
            if (we3 && wa3 != 4'd0) m_mem[m_bank][wa3] = wd3;
            if (ctx_save && ctx_restore) m_err = 1;
            else if (ctx_save) begin
                if (m_active) m_err = 1;
                else begin m_saved = m_bank; m_bank = ctx_bank; m_active = 1; end
            end else if (ctx_restore) begin
                if (!m_active) m_err = 1;
                else begin m_bank = m_saved; m_active = 0; end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we3 = 0; ctx_save = 0; ctx_restore = 0; reset = 0;
    endtask

    task automatic do_reset();
        reset = 1; we3 = 0; ctx_save = 0; ctx_restore = 0;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++;
        if (cur_bank !== 1'b0 || ctx_active !== 1'b0 || ctx_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctx: bank=%0d act=%0b err=%0b required 0/0/0", cur_bank, ctx_active, ctx_err);
        end
        for (int a = 0; a < 16; a++) begin
            ra1 = 4'(a); ra2 = 4'(15 - a); #1;
            tests++;
            if (rd1 !== 8'h00 || rd2 !== 8'h00) begin
                fails++;
                $display("FAIL reset_read a=%0d: rd1=%h rd2=%h required 00", a, rd1, rd2);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_write_read();
        we3 = 1; wa3 = 5; wd3 = 8'hA5; tick();
        we3 = 0; ra1 = 5; #1;
        tests++;
        if (rd1 !== 8'hA5 || rd1_nb !== 8'hA5) begin
            fails++;
            $display("FAIL write_r5: rd1=%h rd1_nb=%h required a5", rd1, rd1_nb);
        end
        we3 = 1; wa3 = 0; wd3 = 8'hFF; ra1 = 0; #1;
        tests++;
        if (rd1 !== 8'h00) begin
            fails++;
            $display("FAIL r0_bypass: rd1=%h required 00", rd1);
        end
        tick();
        we3 = 0; #1;
        tests++;
        if (rd1 !== 8'h00 || rd1_nb !== 8'h00) begin
            fails++;
            $display("FAIL r0_write: rd1=%h rd1_nb=%h required 00", rd1, rd1_nb);
        end
        $display("[TB] test_write_read done");
    endtask

    task automatic test_bypass();
        we3 = 1; wa3 = 3; wd3 = 8'h3C; ra2 = 3; #1;
        tests++;
        if (rd2 !== 8'h3C || rd2_nb !== 8'h00) begin
            fails++;
            $display("FAIL bypass_same_cycle: rd2=%h rd2_nb=%h required 3c/00", rd2, rd2_nb);
        end
        tick();
        we3 = 0; #1;
        tests++;
        if (rd2 !== 8'h3C || rd2_nb !== 8'h3C) begin
            fails++;
            $display("FAIL bypass_next_cycle: rd2=%h rd2_nb=%h required 3c", rd2, rd2_nb);
        end
        $display("[TB] test_bypass done");
    endtask

    task automatic test_context();
        we3 = 1; wa3 = 2; wd3 = 8'h11; tick();
        we3 = 0; ctx_save = 1; ctx_bank = 1; ra1 = 2; #1;
        tests++;
        if (rd1 !== 8'h11 || cur_bank !== 1'b0) begin
            fails++;
            $display("FAIL save_cycle_old_bank: rd1=%h bank=%0d required 11/0", rd1, cur_bank);
        end
        tick();
        ctx_save = 0; #1;
        tests++;
        if (cur_bank !== 1'b1 || ctx_active !== 1'b1 || rd1 !== 8'h00) begin
            fails++;
            $display("FAIL saved_bank1: bank=%0d act=%0b rd1=%h required 1/1/00", cur_bank, ctx_active, rd1);
        end
        we3 = 1; wa3 = 2; wd3 = 8'h22; tick();
        we3 = 0; #1;
        tests++;
        if (rd1 !== 8'h22) begin
            fails++;
            $display("FAIL bank1_r2: rd1=%h required 22", rd1);
        end
        ctx_restore = 1; tick();
        ctx_restore = 0; #1;
        tests++;
        if (cur_bank !== 1'b0 || ctx_active !== 1'b0 || rd1 !== 8'h11 || ctx_err !== 1'b0) begin
            fails++;
            $display("FAIL restore_bank0: bank=%0d act=%0b rd1=%h err=%0b required 0/0/11/0",
                     cur_bank, ctx_active, rd1, ctx_err);
        end
        $display("[TB] test_context done");
    endtask

    task automatic test_write_during_save();
        we3 = 1; wa3 = 4; wd3 = 8'h77; ctx_save = 1; ctx_bank = 1; tick();
        idle_inputs(); ra1 = 4; #1;
        tests++;
        if (rd1 !== 8'h00 || cur_bank !== 1'b1) begin
            fails++;
            $display("FAIL save_write_bank1: rd1=%h bank=%0d required 00/1", rd1, cur_bank);
        end
        ctx_restore = 1; tick();
        ctx_restore = 0; #1;
        tests++;
        if (rd1 !== 8'h77) begin
            fails++;
            $display("FAIL save_write_bank0: rd1=%h required 77", rd1);
        end
        $display("[TB] test_write_during_save done");
    endtask

    task automatic test_errors();
        do_reset();
        ctx_save = 1; ctx_restore = 1; ctx_bank = 1; tick();
        idle_inputs(); #1;
        tests++;
        if (ctx_err !== 1'b1 || cur_bank !== 1'b0 || ctx_active !== 1'b0) begin
            fails++;
            $display("FAIL err_both: err=%0b bank=%0d act=%0b required 1/0/0", ctx_err, cur_bank, ctx_active);
        end
        do_reset();
        ctx_restore = 1; tick();
        idle_inputs(); #1;
        tests++;
        if (ctx_err !== 1'b1 || cur_bank !== 1'b0 || ctx_active !== 1'b0) begin
            fails++;
            $display("FAIL err_restore_idle: err=%0b bank=%0d act=%0b required 1/0/0", ctx_err, cur_bank, ctx_active);
        end
        do_reset();
        ctx_save = 1; ctx_bank = 1; tick();
        ctx_bank = 0; tick();
        idle_inputs(); #1;
        tests++;
        if (ctx_err !== 1'b1 || cur_bank !== 1'b1 || ctx_active !== 1'b1) begin
            fails++;
            $display("FAIL err_nested_save: err=%0b bank=%0d act=%0b required 1/1/1", ctx_err, cur_bank, ctx_active);
        end
        ctx_save = 1; ctx_restore = 1; tick();
        idle_inputs(); #1;
        tests++;
        if (cur_bank !== 1'b1 || ctx_active !== 1'b1) begin
            fails++;
            $display("FAIL err_both_saved: bank=%0d act=%0b required 1/1", cur_bank, ctx_active);
        end
        $display("[TB] test_errors done");
    endtask

    task automatic test_reset_saved();
        do_reset();
        we3 = 1; wa3 = 6; wd3 = 8'h66; tick();
        we3 = 0; ctx_save = 1; ctx_bank = 1; tick();
        ctx_save = 0; we3 = 1; wa3 = 9; wd3 = 8'h99; tick();
        ctx_restore = 1; tick();
        ctx_restore = 0; we3 = 1; wa3 = 9; wd3 = 8'h90; ctx_save = 1; ctx_bank = 1; tick();
        reset = 1; we3 = 1; wa3 = 7; wd3 = 8'h55; ctx_save = 0; tick();
        idle_inputs(); #1;
        tests++;
        if (cur_bank !== 1'b0 || ctx_active !== 1'b0 || ctx_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_saved_ctx: bank=%0d act=%0b err=%0b required 0/0/0", cur_bank, ctx_active, ctx_err);
        end
        for (int b = 0; b < 2; b++) begin
            if (b == 1) begin
                ctx_save = 1; ctx_bank = 1; tick();
                ctx_save = 0;
            end
            for (int a = 0; a < 16; a++) begin
                ra1 = 4'(a); ra2 = 4'(a); #1;
                tests++;
                if (rd1 !== 8'h00 || rd2_nb !== 8'h00) begin
                    fails++;
                    $display("FAIL reset_saved_clear b=%0d a=%0d: rd1=%h rd2_nb=%h required 00", b, a, rd1, rd2_nb);
                end
            end
        end
        $display("[TB] test_reset_saved done");
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 63) == 0);
            we3         = $urandom_range(0, 1);
            wa3         = 4'($urandom_range(0, 15));
            wd3         = 8'($urandom);
            ra1         = ($urandom_range(0, 3) == 0) ? wa3 : 4'($urandom_range(0, 15));
            ra2         = 4'($urandom_range(0, 15));
            ctx_save    = ($urandom_range(0, 7) == 0);
            ctx_restore = ($urandom_range(0, 7) == 0);
            ctx_bank    = 1'($urandom_range(0, 1));
            #1;
            tests++;
            bad = 0;
            if (rd1 !== exp_rd(ra1, 1) || rd2 !== exp_rd(ra2, 1)) bad = 1;
            if (rd1_nb !== exp_rd(ra1, 0) || rd2_nb !== exp_rd(ra2, 0)) bad = 1;
            if (cur_bank !== m_bank || ctx_active !== m_active || ctx_err !== m_err) bad = 1;
            if (cur_bank_nb !== m_bank || ctx_active_nb !== m_active || ctx_err_nb !== m_err) bad = 1;
            if (bad != 0) begin
                fails++;
                $display("FAIL random n=%0d: rd1=%h/%h rd2=%h/%h nb=%h,%h/%h,%h bank=%0d/%0d act=%0b/%0b err=%0b/%0b (actual/required)",
                         n, rd1, exp_rd(ra1, 1), rd2, exp_rd(ra2, 1), rd1_nb, rd2_nb,
                         exp_rd(ra1, 0), exp_rd(ra2, 0), cur_bank, m_bank,
                         ctx_active, m_active, ctx_err, m_err);
            end
            tick();
        end
        idle_inputs();
        $display("[TB] test_random done");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_context();
        test_write_during_save();
        test_errors();
        test_reset_saved();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
